// File: rtl/aes_uart_pkg.sv
// Shared types and constants for the block UART transmitter.
// Holds the top FSM state type and block geometry.
package aes_uart_pkg;

  localparam int BLK_W  = 128;
  localparam int NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

endpackage

// File: rtl/uart_bit_serializer.sv
// 8N1 frame serializer: start, 8 data bits LSB first, stop.
// A start pulse loads a new frame, even on the last stop cycle.
module uart_bit_serializer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       tx_o,
  output logic       last_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

  logic          active_q, active_d;
  logic [9:0]    shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          bit_end;
  logic          last;

  // Frame register and bit/cycle counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      shift_q  <= '0;
      bit_q    <= '0;
      cyc_q    <= '0;
    end else begin
      active_q <= active_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      cyc_q    <= cyc_d;
    end
  end

  // Advance one cycle within the bit, or move to the next bit.
  always_comb begin
    active_d = active_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    cyc_d    = cyc_q;
    bit_end  = active_q && (cyc_q == CYC_LAST);
    last     = bit_end && (bit_q == 4'd9);
    if (start_i) begin
      active_d = 1'b1;
      shift_d  = {1'b1, byte_i, 1'b0};
      bit_d    = '0;
      cyc_d    = '0;
    end else if (active_q) begin
      if (bit_end) begin
        cyc_d = '0;
        if (last) begin
          active_d = 1'b0;
        end else begin
          shift_d = {1'b1, shift_q[9:1]};
          bit_d   = bit_q + 4'd1;
        end
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  assign tx_o   = active_q ? shift_q[0] : 1'b1;
  assign last_o = last;

endmodule

// File: rtl/aes_block_uart_tx.sv
// Sends a 128-bit block as 16 UART bytes, MSB byte first,
// with idle-high gaps between bytes of one block.
module aes_block_uart_tx
  import aes_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_CYCLES   = 100000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             blk_valid,
  input  logic [BLK_W-1:0] blk_data,
  output logic             blk_ready,
  output logic             tx,
  output logic             busy,
  output logic [3:0]       byte_idx,
  output logic             blk_done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [3:0] IDX_LAST = 4'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] data_q, data_d;
  logic [3:0]       idx_q, idx_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ser_start;
  logic [7:0]       ser_byte;
  logic             ser_last;
  logic             done;

  // State, remaining-bytes shift register, index and gap count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Next-state logic; data_q always holds the next byte at its top.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    ser_start = 1'b0;
    ser_byte  = data_q[BLK_W-1 -: 8];
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (blk_valid) begin
          ser_start = 1'b1;
          ser_byte  = blk_data[BLK_W-1 -: 8];
          data_d    = {blk_data[BLK_W-9:0], 8'h00};
          idx_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (ser_last) begin
          if (idx_q == IDX_LAST) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else if (GAP_CYCLES == 0) begin
            ser_start = 1'b1;
            data_d    = {data_q[BLK_W-9:0], 8'h00};
            idx_d     = idx_q + 4'd1;
          end else begin
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          ser_start = 1'b1;
          data_d    = {data_q[BLK_W-9:0], 8'h00};
          idx_d     = idx_q + 4'd1;
          state_d   = SEND;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  uart_bit_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clock  (clock),
    .reset_n(reset_n),
    .start_i(ser_start),
    .byte_i (ser_byte),
    .tx_o   (tx),
    .last_o (ser_last)
  );

  assign blk_ready = (state_q == IDLE);
  assign busy      = ~blk_ready;
  assign byte_idx  = idx_q;
  assign blk_done  = done;

endmodule
